// File: rtl/i2c_slave_target.sv
// i2c_slave_target: oversampled I2C target with 7-bit address match, write receive and read transmit.
// Define I2C_GLITCH_FILTER_EN to require 3 agreeing samples before SCL/SDA are allowed to change.
module i2c_slave_target #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       ack_error
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK} state_t;
    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_d, sda_d;
    logic scl_rise, scl_fall, start, stop, last;
    logic [2:0] cnt, cnt_nxt;
    logic [7:0] shift, shift_nxt, rx_data_nxt, byte_in;
    logic rw, rw_nxt, sda_oe_nxt, rx_valid_nxt, tx_req_nxt, busy_nxt, ack_error_nxt;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_h, sda_h;
    logic scl_q, sda_q;
    // The current sample plus two history samples must agree; otherwise hold the last value.
    assign scl_s = &{scl_h, scl_sync[SYNC_STAGES-1]} ? 1'b1 : ~|{scl_h, scl_sync[SYNC_STAGES-1]} ? 1'b0 : scl_q;
    assign sda_s = &{sda_h, sda_sync[SYNC_STAGES-1]} ? 1'b1 : ~|{sda_h, sda_sync[SYNC_STAGES-1]} ? 1'b0 : sda_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            scl_h <= '1;
            sda_h <= '1;
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_h <= {scl_h[0], scl_sync[SYNC_STAGES-1]};
            sda_h <= {sda_h[0], sda_sync[SYNC_STAGES-1]};
            scl_q <= scl_s;
            sda_q <= sda_s;
        end
`else
    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop     = scl_s & scl_d & ~sda_d & sda_s;
    assign last     = cnt == 3'd0;
    assign byte_in  = {shift[6:0], sda_s};

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 3'd7;
            shift     <= 8'd0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            ack_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shift     <= shift_nxt;
            rw        <= rw_nxt;
            sda_oe    <= sda_oe_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            tx_req    <= tx_req_nxt;
            busy      <= busy_nxt;
            ack_error <= ack_error_nxt;
        end

    // In the ACK states sda_oe doubles as the phase flag: low before the ACK clock, high during it.
    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = ADDR;
        else if (stop)
            state_nxt = IDLE;
        else
            case (state)
                ADDR:     state_nxt = scl_rise && last ? (byte_in[7:1] == SLAVE_ADDR ? ADDR_ACK : IDLE) : state;
                ADDR_ACK: state_nxt = scl_fall && sda_oe ? (rw ? RD_DATA : WR_DATA) : state;
                WR_DATA:  state_nxt = scl_rise && last ? WR_ACK : state;
                WR_ACK:   state_nxt = scl_fall && sda_oe ? WR_DATA : state;
                RD_DATA:  state_nxt = scl_fall && last ? RD_ACK : state;
                RD_ACK:   state_nxt = scl_rise && sda_s ? IDLE : scl_fall ? RD_DATA : state;
                default:  state_nxt = state;
            endcase
    end

    always_comb begin
        cnt_nxt       = cnt;
        shift_nxt     = shift;
        rw_nxt        = rw;
        sda_oe_nxt    = sda_oe;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        tx_req_nxt    = 1'b0;
        busy_nxt      = busy;
        ack_error_nxt = ack_error;
        if (start) begin
            cnt_nxt       = 3'd7;
            sda_oe_nxt    = 1'b0;
            ack_error_nxt = 1'b0;
        end else if (stop) begin
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else
            case (state)
                ADDR, WR_DATA: if (scl_rise) begin
                    shift_nxt = byte_in;
                    cnt_nxt   = last ? 3'd7 : cnt - 3'd1;
                    if (last && state == ADDR) begin
                        busy_nxt = byte_in[7:1] == SLAVE_ADDR;
                        rw_nxt   = byte_in[0];
                    end
                    if (last && state == WR_DATA) begin
                        rx_data_nxt  = byte_in;
                        rx_valid_nxt = 1'b1;
                    end
                end
                ADDR_ACK, WR_ACK: if (scl_fall) begin
                    sda_oe_nxt = ~sda_oe;
                    if (sda_oe && state == ADDR_ACK && rw) begin
                        shift_nxt  = tx_data;
                        tx_req_nxt = 1'b1;
                        sda_oe_nxt = ~tx_data[7];
                    end
                end
                RD_DATA: if (scl_fall) begin
                    shift_nxt  = shift << 1;
                    cnt_nxt    = last ? 3'd7 : cnt - 3'd1;
                    sda_oe_nxt = last ? 1'b0 : ~shift[6];
                end
                RD_ACK: if (scl_rise && sda_s) begin
                    ack_error_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                    sda_oe_nxt    = 1'b0;
                end else if (scl_fall) begin
                    shift_nxt  = tx_data;
                    tx_req_nxt = 1'b1;
                    sda_oe_nxt = ~tx_data[7];
                end
                default: ;
            endcase
    end
endmodule
